bus_source_arbiter: RTL

Arbiter and sequencer for the 32-bit datapath bus source multiplexer. It accepts per-source drive requests from control logic and grants the bus to one source at a time using round-robin order. It produces the 5-bit select code that steers the bus mux, plus a one-hot grant and a valid flag. Grant hold time per source is bounded, and a turnaround cycle separates successive owners.

---
 rtl/bus_arb_pkg.sv | 40 ++++
 rtl/bus_source_arbiter_if.sv | 29 ++
 rtl/rr_pick.sv | 39 +++
 rtl/bus_source_arbiter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared constants and types for the bus source arbiter.
// Source indices double as the bus mux select codes.
package bus_arb_pkg;

  localparam int unsigned SRC_R0     = 0;
  localparam int unsigned SRC_R1     = 1;
  localparam int unsigned SRC_R2     = 2;
  localparam int unsigned SRC_R3     = 3;
  localparam int unsigned SRC_R4     = 4;
  localparam int unsigned SRC_R5     = 5;
  localparam int unsigned SRC_R6     = 6;
  localparam int unsigned SRC_R7     = 7;
  localparam int unsigned SRC_R8     = 8;
  localparam int unsigned SRC_R9     = 9;
  localparam int unsigned SRC_R10    = 10;
  localparam int unsigned SRC_R11    = 11;
  localparam int unsigned SRC_R12    = 12;
  localparam int unsigned SRC_R13    = 13;
  localparam int unsigned SRC_R14    = 14;
  localparam int unsigned SRC_R15    = 15;
  localparam int unsigned SRC_HI     = 16;
  localparam int unsigned SRC_LO     = 17;
  localparam int unsigned SRC_ZHIGH  = 18;
  localparam int unsigned SRC_ZLOW   = 19;
  localparam int unsigned SRC_PC     = 20;
  localparam int unsigned SRC_MDR    = 21;
  localparam int unsigned SRC_INPORT = 22;
  localparam int unsigned SRC_CSIGN  = 23;

  localparam int unsigned NUM_SRC_DEFAULT  = 24;
  localparam int unsigned SEL_W_DEFAULT    = 5;
  localparam int unsigned HOLD_MAX_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } arb_state_t;

endpackage

// File: rtl/bus_source_arbiter_if.sv
// Request/grant bundle between bus control logic (master) and the arbiter (slave).
interface bus_source_arbiter_if #(
    parameter int unsigned NUM_SRC = 24,
    parameter int unsigned SEL_W   = 5
);

    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] grant;
    logic [SEL_W-1:0]   bus_sel;
    logic               bus_valid;
    logic               preempt;

    modport master (
        output req,
        input  grant,
        input  bus_sel,
        input  bus_valid,
        input  preempt
    );

    modport slave (
        input  req,
        output grant,
        output bus_sel,
        output bus_valid,
        output preempt
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to 0.
// Rotates req so ptr lands at bit 0, priority-encodes, then adds ptr back modulo N.
module rr_pick #(
    parameter int unsigned N = 24,
    parameter int unsigned W = 5
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [N-1:0] rot;
    logic [W-1:0] offset;
    int unsigned  sum;

    assign rot = N'({req, req} >> ptr);

    always_comb begin
        found  = 1'b0;
        offset = '0;
        // Descending scan so the lowest set bit of the rotated vector wins.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found  = 1'b1;
                offset = W'(i);
            end
        end
    end

    always_comb begin
        sum = 32'(ptr) + 32'(offset);
        if (sum >= N) begin
            sum = sum - N;
        end
        idx = W'(sum);
    end

endmodule

// File: rtl/bus_source_arbiter.sv
// Round-robin bus source arbiter with bounded hold time and a turnaround cycle.
// Optional fixed-priority source enabled with `define BUS_ARB_PRIO_EN.
module bus_source_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC  = NUM_SRC_DEFAULT,
    parameter int unsigned SEL_W    = SEL_W_DEFAULT,
    parameter int unsigned HOLD_MAX = HOLD_MAX_DEFAULT
`ifdef BUS_ARB_PRIO_EN
    ,
    parameter int unsigned PRIO_SRC = SRC_MDR
`endif
) (
    input logic                 clock,
    input logic                 clear,
    bus_source_arbiter_if.slave bus
);

    arb_state_t         stateQ, stateD;
    logic [NUM_SRC-1:0] grantQ, grantD;
    logic [SEL_W-1:0]   selQ, selD;
    logic               validQ, validD;
    logic               preemptQ, preemptD;
    logic [7:0]         holdCntQ, holdCntD;
    logic [SEL_W-1:0]   rrPtrQ, rrPtrD;

    logic               pickFound;
    logic [SEL_W-1:0]   pickIdx;
    logic               winFound;
    logic [SEL_W-1:0]   winIdx;
    logic               ownerReq;
    logic [SEL_W-1:0]   nextPtr;
    logic               advancePtr;

    rr_pick #(
        .N(NUM_SRC),
        .W(SEL_W)
    ) u_rr_pick (
        .req  (bus.req),
        .ptr  (rrPtrQ),
        .found(pickFound),
        .idx  (pickIdx)
    );

    always_comb begin
        winFound = pickFound;
        winIdx   = pickIdx;
`ifdef BUS_ARB_PRIO_EN
        if (bus.req[PRIO_SRC]) begin
            winFound = 1'b1;
            winIdx   = SEL_W'(PRIO_SRC);
        end
`endif
    end

    assign ownerReq = bus.req[selQ];
    assign nextPtr  = SEL_W'((32'(selQ) + 32'd1) % NUM_SRC);

`ifdef BUS_ARB_PRIO_EN
    // Releasing the priority source must not disturb the round-robin rotation.
    assign advancePtr = (32'(selQ) != PRIO_SRC);
`else
    assign advancePtr = 1'b1;
`endif

    always_comb begin
        stateD   = stateQ;
        grantD   = grantQ;
        selD     = selQ;
        validD   = validQ;
        preemptD = 1'b0;
        holdCntD = holdCntQ;
        rrPtrD   = rrPtrQ;

        unique case (stateQ)
            IDLE, TURN: begin
                grantD   = '0;
                validD   = 1'b0;
                holdCntD = '0;
                stateD   = IDLE;
                // selD keeps the last owner so the mux never sees a transient code.
                if (winFound) begin
                    grantD[winIdx] = 1'b1;
                    selD           = winIdx;
                    validD         = 1'b1;
                    holdCntD       = 8'd1;
                    stateD         = GRANT;
                end
            end

            GRANT: begin
                if (!ownerReq || holdCntQ == 8'(HOLD_MAX)) begin
                    stateD   = TURN;
                    grantD   = '0;
                    validD   = 1'b0;
                    preemptD = ownerReq;
                    if (advancePtr) begin
                        rrPtrD = nextPtr;
                    end
                end else begin
                    holdCntD = holdCntQ + 8'd1;
                end
            end

            default: begin
                stateD = IDLE;
                grantD = '0;
                validD = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            stateQ   <= IDLE;
            grantQ   <= '0;
            selQ     <= '0;
            validQ   <= 1'b0;
            preemptQ <= 1'b0;
            holdCntQ <= '0;
            rrPtrQ   <= '0;
        end else begin
            stateQ   <= stateD;
            grantQ   <= grantD;
            selQ     <= selD;
            validQ   <= validD;
            preemptQ <= preemptD;
            holdCntQ <= holdCntD;
            rrPtrQ   <= rrPtrD;
        end
    end

    assign bus.grant     = grantQ;
    assign bus.bus_sel   = selQ;
    assign bus.bus_valid = validQ;
    assign bus.preempt   = preemptQ;

endmodule
